// File: rtl/divider_iter.sv
// Handshaked iterative restoring divider, BITS_PER_CYCLE quotient bits per cycle.
// Define DIVIDER_SIGNED_EN to honour in_signed (two's-complement operands).
module divider_iter #(
    parameter int DIVIDEND_WIDTH = 32,
    parameter int DIVISOR_WIDTH  = 16,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_signed,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIVIDEND_WIDTH-1:0] quotient,
    output logic [DIVISOR_WIDTH-1:0]  remainder,
    output logic                      overflow
);

    localparam int DW    = DIVIDEND_WIDTH;
    localparam int SW    = DIVISOR_WIDTH;
    localparam int ITERS = DW / BITS_PER_CYCLE;
    localparam int CW    = $clog2(ITERS + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_INIT = CW'(ITERS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_r, state_s;
    logic [CW-1:0]   cnt_r;
    logic [DW-1:0]   dvd_r;        // dividend bits shift out, quotient bits shift in
    logic [SW-1:0]   dvs_r;
    logic [SW:0]     rem_r;
    logic            ovf_r;
    logic            in_ready_r, out_valid_r, overflow_r;
    logic [DW-1:0]   quotient_r;
    logic [SW-1:0]   remainder_r;

    logic            accept_s, dz_s, sovf_s;
    logic [DW-1:0]   dvd_mag_s, dvd_nx_s, quo_fix_s;
    logic [SW-1:0]   dvs_mag_s, rem_fix_s;
    logic [SW:0]     rem_nx_s;

    assign accept_s  = in_valid && in_ready_r;
    assign dz_s      = (divisor == {SW{1'b0}});
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign quotient  = quotient_r;
    assign remainder = remainder_r;
    assign overflow  = overflow_r;

`ifdef DIVIDER_SIGNED_EN
    logic dvd_neg_s, dvs_neg_s;
    logic neg_q_r, neg_r_r;

    assign dvd_neg_s = in_signed & dividend[DW-1];
    assign dvs_neg_s = in_signed & divisor[SW-1];
    assign dvd_mag_s = dvd_neg_s ? -dividend : dividend;
    assign dvs_mag_s = dvs_neg_s ? -divisor : divisor;
    // Most-negative / -1 runs through the datapath normally; only the flag is forced.
    assign sovf_s    = in_signed && (dividend == {1'b1, {(DW-1){1'b0}}})
                                 && (divisor == {SW{1'b1}});
    assign quo_fix_s = neg_q_r ? -dvd_r : dvd_r;
    assign rem_fix_s = neg_r_r ? -rem_r[SW-1:0] : rem_r[SW-1:0];

    // Result sign flags captured with the operands
    always_ff @(posedge clk) begin
        if (reset) begin
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
        end else if (state_r == IDLE && accept_s) begin
            neg_q_r <= dvd_neg_s ^ dvs_neg_s;
            neg_r_r <= dvd_neg_s;
        end
    end
`else
    logic unused_s;

    assign unused_s  = in_signed;
    assign dvd_mag_s = dividend;
    assign dvs_mag_s = divisor;
    assign sovf_s    = 1'b0;
    assign quo_fix_s = dvd_r;
    assign rem_fix_s = rem_r[SW-1:0];
`endif

    // Cascaded restoring steps for one BUSY cycle
    always_comb begin
        rem_nx_s = rem_r;
        dvd_nx_s = dvd_r;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            rem_nx_s = {rem_nx_s[SW-1:0], dvd_nx_s[DW-1]};
            if (rem_nx_s >= {1'b0, dvs_r}) begin
                rem_nx_s = rem_nx_s - {1'b0, dvs_r};
                dvd_nx_s = {dvd_nx_s[DW-2:0], 1'b1};
            end else begin
                dvd_nx_s = {dvd_nx_s[DW-2:0], 1'b0};
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = dz_s ? DONE : BUSY;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == CNT_ONE) begin
                    state_s = FIXUP;
                end else begin
                    state_s = BUSY;
                end
            end
            FIXUP:   state_s = DONE;
            DONE: begin
                if (out_valid_r && out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r       <= {CW{1'b0}};
            dvd_r       <= {DW{1'b0}};
            dvs_r       <= {SW{1'b0}};
            rem_r       <= {(SW+1){1'b0}};
            ovf_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            quotient_r  <= {DW{1'b0}};
            remainder_r <= {SW{1'b0}};
            overflow_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        in_ready_r <= 1'b0;
                        cnt_r      <= CNT_INIT;
                        dvd_r      <= dvd_mag_s;
                        dvs_r      <= dvs_mag_s;
                        rem_r      <= {(SW+1){1'b0}};
                        ovf_r      <= sovf_s;
                        if (dz_s) begin
                            quotient_r  <= {DW{1'b1}};
                            remainder_r <= dividend[SW-1:0];
                            overflow_r  <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    dvd_r <= dvd_nx_s;
                    rem_r <= rem_nx_s;
                    cnt_r <= cnt_r - CNT_ONE;
                end
                FIXUP: begin
                    quotient_r  <= quo_fix_s;
                    remainder_r <= rem_fix_s;
                    overflow_r  <= ovf_r;
                    out_valid_r <= 1'b1;
                end
                DONE: begin
                    // Divide-by-zero enters DONE with out_valid low; raise it one cycle later
                    if (!out_valid_r) begin
                        out_valid_r <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    in_ready_r <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_iter.sv
// Directed bench for divider_iter: default instance plus a BITS_PER_CYCLE=4 instance.
module tb_divider_iter;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_signed, out_valid, out_ready, overflow;
    logic [31:0] dividend, quotient;
    logic [15:0] divisor, remainder;
    logic        in_valid4, in_ready4, in_signed4, out_valid4, out_ready4, overflow4;
    logic [31:0] dividend4, quotient4;
    logic [15:0] divisor4, remainder4;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    divider_iter u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_signed(in_signed), .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient),
        .remainder(remainder), .overflow(overflow)
    );

    divider_iter #(.DIVIDEND_WIDTH(32), .DIVISOR_WIDTH(16), .BITS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_signed(in_signed4), .dividend(dividend4), .divisor(divisor4),
        .out_valid(out_valid4), .out_ready(out_ready4), .quotient(quotient4),
        .remainder(remainder4), .overflow(overflow4)
    );

    task automatic start0(input logic [31:0] a, input logic [15:0] b, input logic s);
        @(negedge clk);
        dividend = a; divisor = b; in_signed = s; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait0(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); lat++; @(negedge clk);
        end
    endtask

    task automatic consume0;
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (quotient !== 32'h0 || remainder !== 16'h0 || overflow !== 1'b0) begin
            bad++; $display("FAIL reset_outputs got=%h/%h/%b want=0/0/0", quotient, remainder, overflow); end
        total++; if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin
            bad++; $display("FAIL reset_r4 got=%b/%b want=1/0", in_ready4, out_valid4); end
        reset = 1'b0;
    endtask

    task automatic test_unsigned;
        int lat;
        start0(32'd100000, 16'd7, 1'b0); wait0(lat);
        total++; if (lat !== 33) begin bad++; $display("FAIL u_latency got=%0d want=33", lat); end
        total++; if (quotient !== 32'd14285) begin bad++; $display("FAIL u_quot got=%0d want=14285", quotient); end
        total++; if (remainder !== 16'd5) begin bad++; $display("FAIL u_rem got=%0d want=5", remainder); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL u_ovf got=%b want=0", overflow); end
        consume0();
        start0(32'd7, 16'd100, 1'b0); wait0(lat);
        total++; if (quotient !== 32'd0 || remainder !== 16'd7) begin
            bad++; $display("FAIL u_small got=%0d r%0d want=0 r7", quotient, remainder); end
        consume0();
    endtask

    task automatic test_div0;
        int lat;
        start0(32'h12345678, 16'h0000, 1'b0); wait0(lat);
        total++; if (lat !== 1) begin bad++; $display("FAIL dz_latency got=%0d want=1", lat); end
        total++; if (quotient !== 32'hFFFFFFFF) begin bad++; $display("FAIL dz_quot got=%h want=ffffffff", quotient); end
        total++; if (remainder !== 16'h5678) begin bad++; $display("FAIL dz_rem got=%h want=5678", remainder); end
        total++; if (overflow !== 1'b1 || in_ready !== 1'b0) begin
            bad++; $display("FAIL dz_flags got ovf=%b rdy=%b want ovf=1 rdy=0", overflow, in_ready); end
        consume0();
    endtask

    task automatic test_signed;
        int lat;
`ifdef DIVIDER_SIGNED_EN
        start0(32'hFFFFFF9C, 16'd7, 1'b1); wait0(lat);
        total++; if (lat !== 33) begin bad++; $display("FAIL s_latency got=%0d want=33", lat); end
        total++; if (quotient !== 32'hFFFFFFF2 || remainder !== 16'hFFFE || overflow !== 1'b0) begin
            bad++; $display("FAIL s_neg100_7 got=%h r%h o%b want=fffffff2 rfffe o0", quotient, remainder, overflow); end
        consume0();
        start0(32'h80000000, 16'hFFFF, 1'b1); wait0(lat);
        total++; if (quotient !== 32'h80000000 || remainder !== 16'h0 || overflow !== 1'b1 || lat !== 33) begin
            bad++; $display("FAIL s_ovf got=%h r%h o%b lat%0d want=80000000 r0 o1 lat33", quotient, remainder, overflow, lat); end
        consume0();
        start0(32'd100, 16'hFFF9, 1'b1); wait0(lat);
        total++; if (quotient !== 32'hFFFFFFF2 || remainder !== 16'h0002) begin
            bad++; $display("FAIL s_100_neg7 got=%h r%h want=fffffff2 r0002", quotient, remainder); end
        consume0();
        start0(32'h00010000, 16'h8000, 1'b1); wait0(lat);
        total++; if (quotient !== 32'hFFFFFFFE || remainder !== 16'h0) begin
            bad++; $display("FAIL s_minneg_dvs got=%h r%h want=fffffffe r0000", quotient, remainder); end
        consume0();
`else
        start0(32'hFFFFFF9C, 16'd7, 1'b1); wait0(lat);
        total++; if (quotient !== 32'h24924916 || remainder !== 16'd2 || overflow !== 1'b0 || lat !== 33) begin
            bad++; $display("FAIL nosign_100_7 got=%h r%h o%b lat%0d want=24924916 r0002 o0 lat33", quotient, remainder, overflow, lat); end
        consume0();
        start0(32'h80000000, 16'hFFFF, 1'b1); wait0(lat);
        total++; if (quotient !== 32'h00008000 || remainder !== 16'h8000 || overflow !== 1'b0) begin
            bad++; $display("FAIL nosign_ovf got=%h r%h o%b want=00008000 r8000 o0", quotient, remainder, overflow); end
        consume0();
`endif
    endtask

    task automatic test_radix4;
        int lat;
        @(negedge clk);
        dividend4 = 32'hFFFFFFFF; divisor4 = 16'hFFFF; in_valid4 = 1'b1;
        @(posedge clk); #1 in_valid4 = 1'b0;
        lat = 0;
        while (!out_valid4 && lat < 200) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        total++; if (lat !== 9) begin bad++; $display("FAIL r4_latency got=%0d want=9", lat); end
        total++; if (quotient4 !== 32'h00010001 || remainder4 !== 16'h0 || overflow4 !== 1'b0) begin
            bad++; $display("FAIL r4_result got=%h r%h o%b want=00010001 r0000 o0", quotient4, remainder4, overflow4); end
        @(negedge clk); out_ready4 = 1'b1;
        @(posedge clk); #1 out_ready4 = 1'b0;
    endtask

    task automatic test_backpressure;
        int lat;
        start0(32'd123456789, 16'd1000, 1'b0);
        // operand changes and in_valid while busy must be ignored
        @(negedge clk); dividend = 32'hDEADBEEF; divisor = 16'd1; in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        wait0(lat);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b want=1", out_valid); end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (quotient !== 32'd123456 || remainder !== 16'd789 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                bad++; $display("FAIL bp_hold%0d got=%0d r%0d rdy%b v%b want=123456 r789 rdy0 v1",
                                i, quotient, remainder, in_ready, out_valid);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL bp_release got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid); end
        start0(32'd1000, 16'd3, 1'b0); wait0(lat);
        total++; if (quotient !== 32'd333 || remainder !== 16'd1 || lat !== 33) begin
            bad++; $display("FAIL b2b got=%0d r%0d lat%0d want=333 r1 lat33", quotient, remainder, lat); end
        consume0();
    endtask

    task automatic test_reset_busy;
        int lat;
        start0(32'd100000, 16'd7, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL rb_flags got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); end
        total++; if (quotient !== 32'h0 || remainder !== 16'h0 || overflow !== 1'b0) begin
            bad++; $display("FAIL rb_outputs got=%h/%h/%b want=0/0/0", quotient, remainder, overflow); end
        repeat (40) @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rb_no_result got=%b want=0", out_valid); end
        start0(32'd50, 16'd5, 1'b0); wait0(lat);
        total++; if (quotient !== 32'd10 || remainder !== 16'd0 || lat !== 33) begin
            bad++; $display("FAIL rb_after got=%0d r%0d lat%0d want=10 r0 lat33", quotient, remainder, lat); end
        consume0();
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_signed = 1'b0; dividend = 32'h0; divisor = 16'h0; out_ready = 1'b0;
        in_valid4 = 1'b0; in_signed4 = 1'b0; dividend4 = 32'h0; divisor4 = 16'h0; out_ready4 = 1'b0;
        test_reset();
        test_unsigned();
        test_div0();
        test_signed();
        test_radix4();
        test_backpressure();
        test_reset_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/divider_iter.md
Name: divider_iter

Overview:
- Parametrised, handshaked iterative restoring divider for the FM radio datapath (demodulator gain normalisation and de-emphasis scaling).
- Successor to the fixed 32/16 start-pulse divider, with the following additions:
  - configurable widths;
  - configurable radix (1, 2 or 4 quotient bits per cycle);
  - valid/ready on both sides with output backpressure;
  - optional signed mode.
- One division in flight at a time.

Parameters:
- DIVIDEND_WIDTH, 32, dividend and quotient width. Must be a multiple of BITS_PER_CYCLE.
- DIVISOR_WIDTH, 16, divisor and remainder width. Must be ≤ DIVIDEND_WIDTH.
- BITS_PER_CYCLE, 1, quotient bits resolved per BUSY cycle. Legal values: 1, 2, 4.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  divider can accept operands
- in_signed  in  1  1 = two's-complement operands (see Optional Feature)
- dividend  in  DIVIDEND_WIDTH  numerator
- divisor  in  DIVISOR_WIDTH  denominator
- out_valid  out  1  result valid, held until consumed
- out_ready  in  1  consumer accepts result
- quotient  out  DIVIDEND_WIDTH  result quotient
- remainder  out  DIVISOR_WIDTH  result remainder
- overflow  out  1  divide-by-zero or signed overflow

Behaviour:
- Interface reset:
  - Only one clock and one reset: clk and reset. Reset is synchronous and active-high.
  - Reset values: in_ready=1, out_valid=0, quotient=0, remainder=0, overflow=0. FSM goes to IDLE.
  - Reset mid-operation aborts the operation; no result is produced.
- FSM states: IDLE, BUSY, FIXUP, DONE.
- IDLE:
  - in_ready=1.
  - Accept on the edge where in_valid && in_ready; operands are latched on that edge.
  - If divisor==0: go to DONE with quotient = all ones, remainder = dividend[DIVISOR_WIDTH-1:0], overflow=1.
  - Else: go to BUSY with iteration counter N = DIVIDEND_WIDTH/BITS_PER_CYCLE.
- BUSY:
  - in_ready=0.
  - Each edge shifts BITS_PER_CYCLE dividend bits into the partial remainder.
  - Performs BITS_PER_CYCLE restoring compare/subtract steps combinationally (cascaded) and shifts the quotient bits in.
  - Partial remainder is DIVISOR_WIDTH+1 bits.
  - After N edges, go to FIXUP.
- FIXUP (1 cycle):
  - Apply sign correction.
  - Register quotient, remainder and overflow.
  - Set out_valid and go to DONE.
- DONE:
  - out_valid=1; outputs held stable while out_ready=0.
  - On the edge with out_valid && out_ready: out_valid clears and FSM returns to IDLE.
  - in_ready rises the cycle after that edge. No accept occurs in DONE.
- Latency:
  - Normal division: out_valid rises N+1 cycles after the accept edge. Default: 33.
  - Divide-by-zero: out_valid rises 1 cycle after the accept edge.
- Unsigned results: quotient = floor(dividend/divisor); remainder = dividend − quotient·divisor, always < divisor.
- Signed results:
  - Division runs on operand magnitudes; the divisor is sign-extended.
  - Quotient truncates toward zero: quotient sign = sign(dividend) XOR sign(divisor).
  - Remainder takes the sign of the dividend; a zero remainder is positive.
  - Signed overflow case, dividend = most-negative and divisor = −1: quotient = most-negative, remainder=0, overflow=1. This case is detected at accept and takes the normal latency.
  - Divisor = most-negative DIVISOR_WIDTH value: legal, with magnitude 2^(DIVISOR_WIDTH−1).
- Operand stability: the block ignores operand changes after the accept edge, and ignores in_valid while in_ready=0.

Optional Feature:
- Macro: DIVIDER_SIGNED_EN.
- Defined: in_signed is honoured per transaction; sign handling as in Behaviour; FIXUP performs negation.
- Undefined: in_signed is ignored and treated as 0. There is no sign logic, and signed overflow detection is removed. FIXUP remains, so latency is unchanged.

Test Plan:
- Unsigned, defaults: 100000/7 → quotient=14285, remainder=5, overflow=0. out_valid exactly 33 cycles after the accept edge.
- Divide-by-zero: 0x12345678/0 → quotient=0xFFFFFFFF, remainder=0x5678, overflow=1. out_valid 1 cycle after accept.
- Signed (DIVIDER_SIGNED_EN, in_signed=1):
  - −100/7 → quotient=0xFFFFFFF2 (−14), remainder=0xFFFE (−2).
  - 0x80000000/0xFFFF → quotient=0x80000000, remainder=0, overflow=1.
- BITS_PER_CYCLE=4: 0xFFFFFFFF/0xFFFF → quotient=0x00010001, remainder=0. out_valid 9 cycles after accept.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → outputs stable and in_ready=0. Then pulse out_ready → in_ready=1 next cycle. A back-to-back second operation gives correct results.
- Reset mid-BUSY: assert reset at iteration 10 → next cycle out_valid=0, in_ready=1, outputs 0. A following 50/5 → quotient=10, remainder=0.
